// File: rtl/cdb_writeback_arbiter_pkg.sv
// Shared types and sizing for the CDB writeback arbiter: result packet layout,
// lane count and a modulo-NUM_FU increment used by the round-robin scan.
package cdb_writeback_arbiter_pkg;

    localparam int NUM_FU     = 4;
    localparam int CDB_W      = 2;
    localparam int PHYS_W     = 6;
    localparam int ROB_W      = 6;
    localparam int BUF_DEPTH  = 2;
    localparam int CDB_LANES  = CDB_W;
    localparam int FU_IDX_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int LANE_CNT_W = $clog2(CDB_LANES + 1);
    localparam int CNT_W      = $clog2(BUF_DEPTH + 1);

    typedef struct packed {
        logic [PHYS_W-1:0] tag;
        logic [31:0]       value;
        logic [ROB_W-1:0]  rob_tag;
    } cdb_pkt_t;

    localparam int PKT_W = $bits(cdb_pkt_t);

    // (base + step) mod NUM_FU; both operands are below NUM_FU so one subtract suffices
    function automatic logic [FU_IDX_W-1:0] fu_wrap_inc(input logic [FU_IDX_W-1:0] base,
                                                        input logic [FU_IDX_W-1:0] step);
        logic [FU_IDX_W:0] sum;
        sum = {1'b0, base} + {1'b0, step};
        if (sum >= (FU_IDX_W + 1)'(NUM_FU)) begin
            sum = sum - (FU_IDX_W + 1)'(NUM_FU);
        end else begin
            sum = sum;
        end
        return sum[FU_IDX_W-1:0];
    endfunction

endpackage

// File: rtl/cdb_writeback_arbiter_if.sv
// FU result inputs, flush and CDB broadcast lanes of the writeback arbiter.
interface cdb_writeback_arbiter_if;
    import cdb_writeback_arbiter_pkg::*;

    logic                               flush_pipeline;
    logic [NUM_FU-1:0]                  fu_valid;
    logic [NUM_FU-1:0]                  fu_ready;
    logic [NUM_FU-1:0][PHYS_W-1:0]      fu_dst_tag;
    logic [NUM_FU-1:0][31:0]            fu_value;
    logic [NUM_FU-1:0][ROB_W-1:0]       fu_rob_tag;
    logic [CDB_LANES-1:0]               cdb_valid;
    logic [CDB_LANES-1:0][PHYS_W-1:0]   cdb_tag;
    logic [CDB_LANES-1:0][31:0]         cdb_value;
    logic [CDB_LANES-1:0][ROB_W-1:0]    cdb_rob_tag;

    modport master (
        output flush_pipeline, fu_valid, fu_dst_tag, fu_value, fu_rob_tag,
        input  fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_rob_tag
    );

    modport slave (
        input  flush_pipeline, fu_valid, fu_dst_tag, fu_value, fu_rob_tag,
        output fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_rob_tag
    );

endinterface

// File: rtl/cdb_writeback_arbiter_fifo.sv
// Per-FU result FIFO: power-of-two depth, free-running wrapping pointers,
// synchronous flush that also drops a push presented in the same cycle.
module wb_result_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 44
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [DATA_W-1:0]            head
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNTW   = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNTW-1:0]   count_r;

    // Payload storage; contents are only meaningful below count
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            wr_ptr_r <= push ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
            rd_ptr_r <= pop  ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
            case ({push, pop})
                2'b10:   count_r <= count_r + CNTW'(1);
                2'b01:   count_r <= count_r - CNTW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/cdb_writeback_arbiter.sv
// Buffers results from every FU and broadcasts up to CDB_LANES of them per
// cycle on registered CDB lanes, granting non-empty FIFOs round-robin.
module cdb_writeback_arbiter
    import cdb_writeback_arbiter_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    cdb_writeback_arbiter_if.slave  bus
);
    logic [NUM_FU-1:0]     fu_ready_s;
    logic [NUM_FU-1:0]     push_s;
    logic [NUM_FU-1:0]     nonempty_s;
    logic [NUM_FU-1:0]     grant_s;
    logic [CNT_W-1:0]      count_s    [NUM_FU];
    cdb_pkt_t              push_pkt_s [NUM_FU];
    cdb_pkt_t              head_s     [NUM_FU];

    logic [FU_IDX_W-1:0]   rr_ptr_r;
    logic [FU_IDX_W-1:0]   scan_idx_s;
    logic [FU_IDX_W-1:0]   last_fu_s;
    logic [LANE_CNT_W-1:0] n_grant_s;
    logic [CDB_LANES-1:0]  lane_valid_s;
    logic [FU_IDX_W-1:0]   lane_fu_s  [CDB_LANES];

    logic [CDB_LANES-1:0]  cdb_valid_r;
    cdb_pkt_t              cdb_pkt_r  [CDB_LANES];

    // Readiness comes from registered occupancy only, so a same-cycle pop never opens a slot
    for (genvar f = 0; f < NUM_FU; f++) begin : g_fu
        assign fu_ready_s[f] = (count_s[f] < CNT_W'(BUF_DEPTH)) && !reset;
        assign push_s[f]     = bus.fu_valid[f] & fu_ready_s[f];
        assign nonempty_s[f] = (count_s[f] != '0);
        assign push_pkt_s[f] = '{tag: bus.fu_dst_tag[f], value: bus.fu_value[f],
                                 rob_tag: bus.fu_rob_tag[f]};

        wb_result_fifo #(.DEPTH(BUF_DEPTH), .DATA_W(PKT_W)) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .flush     (bus.flush_pipeline),
            .push      (push_s[f]),
            .push_data (push_pkt_s[f]),
            .pop       (grant_s[f]),
            .count     (count_s[f]),
            .head      (head_s[f])
        );
    end

    assign bus.fu_ready = fu_ready_s;

    // Round-robin scan from rr_ptr; the n-th non-empty FIFO found takes lane n
    always_comb begin
        grant_s      = '0;
        lane_valid_s = '0;
        last_fu_s    = '0;
        scan_idx_s   = '0;
        n_grant_s    = '0;
        for (int l = 0; l < CDB_LANES; l++) begin
            lane_fu_s[l] = '0;
        end
        for (int i = 0; i < NUM_FU; i++) begin
            scan_idx_s = fu_wrap_inc(rr_ptr_r, FU_IDX_W'(i));
            if (nonempty_s[scan_idx_s] && (n_grant_s < LANE_CNT_W'(CDB_LANES))) begin
                grant_s[scan_idx_s] = 1'b1;
                for (int l = 0; l < CDB_LANES; l++) begin
                    if (n_grant_s == LANE_CNT_W'(l)) begin
                        lane_valid_s[l] = 1'b1;
                        lane_fu_s[l]    = scan_idx_s;
                    end else begin
                        lane_valid_s[l] = lane_valid_s[l];
                    end
                end
                last_fu_s = scan_idx_s;
                n_grant_s = n_grant_s + LANE_CNT_W'(1);
            end else begin
                n_grant_s = n_grant_s;
            end
        end
    end

    // Round-robin pointer resumes just past the last FU granted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_r <= '0;
        end else if (bus.flush_pipeline) begin
            rr_ptr_r <= '0;
        end else if (|grant_s) begin
            rr_ptr_r <= fu_wrap_inc(last_fu_s, FU_IDX_W'(1));
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // CDB lane registers; flush kills valid but leaves the data fields untouched
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cdb_valid_r <= '0;
            for (int l = 0; l < CDB_LANES; l++) begin
                cdb_pkt_r[l] <= '0;
            end
        end else if (bus.flush_pipeline) begin
            cdb_valid_r <= '0;
        end else begin
            cdb_valid_r <= lane_valid_s;
            for (int l = 0; l < CDB_LANES; l++) begin
                if (lane_valid_s[l]) begin
                    cdb_pkt_r[l] <= head_s[lane_fu_s[l]];
                end else begin
                    cdb_pkt_r[l] <= cdb_pkt_r[l];
                end
            end
        end
    end

    // Unpack lane registers onto the broadcast bus
    always_comb begin
        bus.cdb_valid = cdb_valid_r;
        for (int l = 0; l < CDB_LANES; l++) begin
            bus.cdb_tag[l]     = cdb_pkt_r[l].tag;
            bus.cdb_value[l]   = cdb_pkt_r[l].value;
            bus.cdb_rob_tag[l] = cdb_pkt_r[l].rob_tag;
        end
    end

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Scoreboard bench for cdb_writeback_arbiter: directed lane-order, flush and
// reset scenarios followed by random traffic with per-FU ordering checks.
module tb_cdb_writeback_arbiter;
    import cdb_writeback_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cdb_writeback_arbiter_if bus ();

    cdb_writeback_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    cdb_pkt_t exp_q [NUM_FU][$];
    cdb_pkt_t src_q [NUM_FU][$];
    int wait_cnt [NUM_FU];
    int max_wait = 0;
    int n_acc = 0;
    int n_bcast = 0;
    int seq = 0;
    logic [31:0] prev_value0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic cdb_pkt_t mk(input logic [PHYS_W-1:0] t, input logic [31:0] v,
                                    input logic [ROB_W-1:0] r);
        cdb_pkt_t p;
        p.tag = t;
        p.value = v;
        p.rob_tag = r;
        return p;
    endfunction

    function automatic bit idle();
        bit e;
        e = 1'b1;
        for (int f = 0; f < NUM_FU; f++) begin
            if (exp_q[f].size() != 0 || src_q[f].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    // Match every valid lane to the FU queue that holds it; it must be that queue's oldest entry
    task automatic monitor();
        logic [NUM_FU-1:0] served;
        cdb_pkt_t got;
        int owner;
        served = '0;
        for (int l = 0; l < CDB_LANES; l++) begin
            if (bus.cdb_valid[l]) begin
                got = mk(bus.cdb_tag[l], bus.cdb_value[l], bus.cdb_rob_tag[l]);
                owner = -1;
                for (int f = 0; f < NUM_FU; f++) begin
                    for (int k = 0; k < exp_q[f].size(); k++) begin
                        if (owner < 0 && exp_q[f][k] == got) owner = f;
                    end
                end
                n_bcast++;
                if (owner < 0) begin
                    check_eq("cdb_known", 64'd0, 64'd1);
                end else begin
                    check_eq("cdb_order", 64'(got), 64'(exp_q[owner][0]));
                    void'(exp_q[owner].pop_front());
                    served[owner] = 1'b1;
                end
            end
        end
        for (int f = 0; f < NUM_FU; f++) begin
            if (exp_q[f].size() > 0 && !served[f]) wait_cnt[f]++;
            else wait_cnt[f] = 0;
            if (wait_cnt[f] > max_wait) max_wait = wait_cnt[f];
        end
    endtask

    // Present source heads, record accepted handshakes, then advance one cycle
    task automatic drive_cycle(input logic flush);
        bus.flush_pipeline = flush;
        for (int f = 0; f < NUM_FU; f++) begin
            if (src_q[f].size() > 0) begin
                bus.fu_valid[f]   = 1'b1;
                bus.fu_dst_tag[f] = src_q[f][0].tag;
                bus.fu_value[f]   = src_q[f][0].value;
                bus.fu_rob_tag[f] = src_q[f][0].rob_tag;
            end else begin
                bus.fu_valid[f]   = 1'b0;
                bus.fu_dst_tag[f] = '0;
                bus.fu_value[f]   = '0;
                bus.fu_rob_tag[f] = '0;
            end
        end
        if (flush) begin
            for (int f = 0; f < NUM_FU; f++) begin
                exp_q[f].delete();
                src_q[f].delete();
            end
        end else begin
            for (int f = 0; f < NUM_FU; f++) begin
                if (bus.fu_valid[f] && bus.fu_ready[f]) begin
                    exp_q[f].push_back(src_q[f].pop_front());
                    n_acc++;
                end
            end
        end
        @(negedge clk);
        bus.flush_pipeline = 1'b0;
        monitor();
    endtask

    task automatic run_until_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (!idle() && n < budget) begin
            drive_cycle(1'b0);
            n++;
        end
        check_eq(tag, 64'(idle()), 64'd1);
    endtask

    task automatic clear_model();
        for (int f = 0; f < NUM_FU; f++) begin
            exp_q[f].delete();
            src_q[f].delete();
            wait_cnt[f] = 0;
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.flush_pipeline = 1'b0;
        bus.fu_valid = '0;
        bus.fu_dst_tag = '0;
        bus.fu_value = '0;
        bus.fu_rob_tag = '0;
        clear_model();

        // reset state
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_ready", 64'(bus.fu_ready), 64'h0);
        check_eq("rst_cdb_valid", 64'(bus.cdb_valid), 64'h0);
        reset = 1'b0;
        #1;
        check_eq("rel_ready", 64'(bus.fu_ready), 64'hF);
        check_eq("rel_cdb_valid", 64'(bus.cdb_valid), 64'h0);
        check_eq("rel_cdb_value", 64'(bus.cdb_value), 64'h0);
        check_eq("rel_cdb_tag", 64'(bus.cdb_tag), 64'h0);

        // single result from FU0
        src_q[0].push_back(mk(6'd5, 32'hDEAD_BEEF, 6'd3));
        drive_cycle(1'b0);
        check_eq("t1_no_bypass", 64'(bus.cdb_valid), 64'h0);
        check_eq("t1_ready", 64'(bus.fu_ready[0]), 64'd1);
        drive_cycle(1'b0);
        check_eq("t1_valid", 64'(bus.cdb_valid), 64'h1);
        check_eq("t1_tag", 64'(bus.cdb_tag[0]), 64'd5);
        check_eq("t1_value", 64'(bus.cdb_value[0]), 64'hDEAD_BEEF);
        check_eq("t1_rob", 64'(bus.cdb_rob_tag[0]), 64'd3);
        drive_cycle(1'b1);

        // all four FUs at once from rr_ptr 0
        for (int f = 0; f < NUM_FU; f++) begin
            src_q[f].push_back(mk(PHYS_W'(f + 8), 32'h2000_0000 + 32'(f), ROB_W'(f + 16)));
        end
        drive_cycle(1'b0);
        drive_cycle(1'b0);
        check_eq("t2_c1_valid", 64'(bus.cdb_valid), 64'h3);
        check_eq("t2_c1_lane0", 64'(bus.cdb_value[0]), 64'h2000_0000);
        check_eq("t2_c1_lane1", 64'(bus.cdb_value[1]), 64'h2000_0001);
        drive_cycle(1'b0);
        check_eq("t2_c2_valid", 64'(bus.cdb_valid), 64'h3);
        check_eq("t2_c2_lane0", 64'(bus.cdb_value[0]), 64'h2000_0002);
        check_eq("t2_c2_lane1", 64'(bus.cdb_value[1]), 64'h2000_0003);
        src_q[3].push_back(mk(6'd1, 32'h2100_0003, 6'd1));
        src_q[0].push_back(mk(6'd2, 32'h2100_0000, 6'd2));
        drive_cycle(1'b0);
        drive_cycle(1'b0);
        check_eq("t2_rr0_lane0", 64'(bus.cdb_value[0]), 64'h2100_0000);
        check_eq("t2_rr0_lane1", 64'(bus.cdb_value[1]), 64'h2100_0003);

        // FU2 burst under contention
        for (int k = 0; k < 4; k++) begin
            src_q[0].push_back(mk(6'd10, 32'h3000_0000 + 32'(k), 6'd0));
            src_q[1].push_back(mk(6'd11, 32'h3000_0100 + 32'(k), 6'd1));
            src_q[3].push_back(mk(6'd13, 32'h3000_0300 + 32'(k), 6'd3));
        end
        for (int k = 0; k < 3; k++) begin
            src_q[2].push_back(mk(6'd12, 32'h3200_0000 + 32'(k), ROB_W'(k)));
        end
        drive_cycle(1'b0);
        drive_cycle(1'b0);
        check_eq("t3_ready2_low", 64'(bus.fu_ready[2]), 64'd0);
        run_until_idle(40, "t3_drain");

        // flush with full FIFOs and FU1 still presenting
        for (int f = 0; f < NUM_FU; f++) begin
            for (int k = 0; k < 6; k++) begin
                src_q[f].push_back(mk(PHYS_W'(f), 32'h4000_0000 + 32'(f * 16 + k), ROB_W'(k)));
            end
        end
        drive_cycle(1'b0);
        drive_cycle(1'b0);
        drive_cycle(1'b0);
        check_eq("t4_fu1_pending", 64'(src_q[1].size() > 0), 64'd1);
        prev_value0 = bus.cdb_value[0];
        drive_cycle(1'b1);
        check_eq("t4_flush_valid", 64'(bus.cdb_valid), 64'h0);
        check_eq("t4_flush_ready", 64'(bus.fu_ready), 64'hF);
        check_eq("t4_data_hold", 64'(bus.cdb_value[0]), 64'(prev_value0));
        for (int k = 0; k < 4; k++) drive_cycle(1'b0);
        check_eq("t4_quiet", 64'(bus.cdb_valid), 64'h0);

        // asynchronous reset in the middle of a burst
        for (int f = 0; f < NUM_FU; f++) begin
            for (int k = 0; k < 6; k++) begin
                src_q[f].push_back(mk(PHYS_W'(f), 32'h5000_0000 + 32'(f * 16 + k), ROB_W'(k)));
            end
        end
        drive_cycle(1'b0);
        drive_cycle(1'b0);
        check_eq("t5_busy", 64'(bus.cdb_valid), 64'h3);
        #2;
        reset = 1'b1;
        #1;
        check_eq("t5_async_valid", 64'(bus.cdb_valid), 64'h0);
        check_eq("t5_async_ready", 64'(bus.fu_ready), 64'h0);
        clear_model();
        bus.fu_valid = '0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("t5_rel_ready", 64'(bus.fu_ready), 64'hF);
        check_eq("t5_rel_valid", 64'(bus.cdb_valid), 64'h0);
        src_q[3].push_back(mk(6'd7, 32'h5500_0003, 6'd7));
        src_q[0].push_back(mk(6'd8, 32'h5500_0000, 6'd8));
        drive_cycle(1'b0);
        drive_cycle(1'b0);
        check_eq("t5_rr0_lane0", 64'(bus.cdb_value[0]), 64'h5500_0000);
        check_eq("t5_rr0_lane1", 64'(bus.cdb_value[1]), 64'h5500_0003);
        run_until_idle(10, "t5_drain");

        // random traffic
        max_wait = 0;
        n_acc = 0;
        n_bcast = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int f = 0; f < NUM_FU; f++) begin
                if (src_q[f].size() == 0 && $urandom_range(0, 1) == 1) begin
                    src_q[f].push_back(mk(PHYS_W'($urandom), 32'h6000_0000 + 32'(seq), ROB_W'($urandom)));
                    seq++;
                end
            end
            drive_cycle(1'b0);
        end
        run_until_idle(50, "t6_drain");
        check_eq("t6_count", 64'(n_bcast), 64'(n_acc));
        check_eq("t6_starve", 64'(max_wait <= 2), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
